// File: rtl/pc_fetch_ctrl.sv
// ============================================================================
// pc_fetch_ctrl
// ----------------------------------------------------------------------------
// Fetch-stage program-counter sequencer for the pipelined MIPS core.
// Owns the PC register and drives instruction-memory requests. The PC steps
// on ihit and holds on stall. Branch/jump/jr redirects resolved downstream
// are applied here, and the block raises the flush/discard strobes for them.
// A redirect that arrives while an icache miss is outstanding is parked in
// pend_pc until the miss returns. The returned (stale) instruction is then
// marked with drop_fetch, and the PC is loaded from pend_pc.
//
// Parameters:
//   RESET_PC    PC value loaded on reset.
//
// Optional feature (compile-time macro PC_HALT_EN):
//   Adds input 'halt' and a HALTED state. In HALTED the PC is frozen,
//   imemREN is low and redirects are ignored; only reset leaves it. A halt
//   seen while a miss drains takes effect once the drain completes.
//
// Ports:
//   CLK         in   1   clock, rising edge
//   nRST        in   1   synchronous active-low reset
//   ihit        in   1   icache returns the instruction at imemaddr
//   stall       in   1   hazard unit: hold fetch
//   pcsrc       in   3   0 SEQ, 1 BEQ, 2 BNE, 3 J, 4 JAL, 5 JR, 6-7 SEQ
//   equal       in   1   branch comparator result
//   imm         in  16   signed word offset for branches
//   jaddr       in  26   jump target field
//   rs_data     in  32   register value for JR
//   res_npc     in  32   PC+4 of the resolving instruction
//   halt        in   1   (PC_HALT_EN only) stop fetching
//   imemaddr    out 32   current fetch address
//   imemREN     out  1   instruction read enable
//   nPC         out 32   imemaddr + 4 (wraps)
//   flush       out  1   squash younger instructions in IF/ID (Mealy)
//   drop_fetch  out  1   instruction returned this cycle is stale (Mealy)
// ============================================================================
module pc_fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        ihit,
    input  logic        stall,
    input  logic [2:0]  pcsrc,
    input  logic        equal,
    input  logic [15:0] imm,
    input  logic [25:0] jaddr,
    input  logic [31:0] rs_data,
    input  logic [31:0] res_npc,
`ifdef PC_HALT_EN
    input  logic        halt,
`endif
    output logic [31:0] imemaddr,
    output logic        imemREN,
    output logic [31:0] nPC,
    output logic        flush,
    output logic        drop_fetch
);

    localparam logic [2:0] SRC_BEQ = 3'd1;
    localparam logic [2:0] SRC_BNE = 3'd2;
    localparam logic [2:0] SRC_J   = 3'd3;
    localparam logic [2:0] SRC_JAL = 3'd4;
    localparam logic [2:0] SRC_JR  = 3'd5;

    localparam logic [1:0] ST_FETCH      = 2'd0;
    localparam logic [1:0] ST_WAIT_DRAIN = 2'd1;
`ifdef PC_HALT_EN
    localparam logic [1:0] ST_HALTED     = 2'd2;
`endif

    logic [31:0] pc_q,      pc_d;
    logic [31:0] pend_pc_q, pend_pc_d;
    logic [1:0]  state_q,   state_d;
    // Low for the first cycle after reset release; fetching starts after that.
    logic        ren_q;
`ifdef PC_HALT_EN
    logic        halt_pend_q, halt_pend_d;
`endif

    logic               taken;
    logic [31:0]        target;
    logic signed [31:0] br_off;

    assign imemaddr = pc_q;
    assign nPC      = pc_q + 32'd4;

`ifdef PC_HALT_EN
    assign imemREN = ren_q && (state_q != ST_HALTED);
`else
    assign imemREN = ren_q;
`endif

    // Redirect decode and target computation
    always_comb begin
        br_off = signed'({{14{imm[15]}}, imm, 2'b00});
        taken  = 1'b0;
        target = res_npc;
        case (pcsrc)
            SRC_BEQ: begin
                taken  = equal;
                target = res_npc + unsigned'(br_off);
            end
            SRC_BNE: begin
                taken  = ~equal;
                target = res_npc + unsigned'(br_off);
            end
            SRC_J, SRC_JAL: begin
                taken  = 1'b1;
                target = {res_npc[31:28], jaddr, 2'b00};
            end
            SRC_JR: begin
                taken  = 1'b1;
                // Mask the low bits instead of slicing so every bit is consumed.
                target = rs_data & 32'hFFFF_FFFC;
            end
            default: begin
                taken  = 1'b0;
                target = res_npc;
            end
        endcase
    end

    // Next-state / next-PC logic
    always_comb begin
        pc_d       = pc_q;
        pend_pc_d  = pend_pc_q;
        state_d    = state_q;
        flush      = 1'b0;
        drop_fetch = 1'b0;
`ifdef PC_HALT_EN
        halt_pend_d = halt_pend_q;
`endif
        if (ren_q) begin
            case (state_q)
                ST_FETCH: begin
                    if (taken) begin
                        // Redirect outranks stall.
                        flush = 1'b1;
                        if (ihit) begin
                            pc_d = target;
                        end else begin
                            // Miss in flight cannot be aborted: park the target.
                            pend_pc_d = target;
                            state_d   = ST_WAIT_DRAIN;
                        end
`ifdef PC_HALT_EN
                    end else if (halt) begin
                        state_d = ST_HALTED;
`endif
                    end else if (ihit && !stall) begin
                        pc_d = nPC;
                    end
                end
                ST_WAIT_DRAIN: begin
`ifdef PC_HALT_EN
                    halt_pend_d = halt_pend_q | halt;
`endif
                    if (taken) begin
                        // Younger redirect replaces the parked one.
                        flush     = 1'b1;
                        pend_pc_d = target;
                    end
                    if (ihit) begin
                        drop_fetch = 1'b1;
                        pc_d       = taken ? target : pend_pc_q;
                        state_d    = ST_FETCH;
`ifdef PC_HALT_EN
                        halt_pend_d = 1'b0;
                        if (halt_pend_q || halt) begin
                            state_d = ST_HALTED;
                        end
`endif
                    end
                end
                default: begin
                    // HALTED (or unused encodings): everything frozen.
                    state_d = state_q;
                end
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            pc_q      <= RESET_PC;
            pend_pc_q <= 32'h0000_0000;
            state_q   <= ST_FETCH;
            ren_q     <= 1'b0;
`ifdef PC_HALT_EN
            halt_pend_q <= 1'b0;
`endif
        end else begin
            pc_q      <= pc_d;
            pend_pc_q <= pend_pc_d;
            state_q   <= state_d;
            ren_q     <= 1'b1;
`ifdef PC_HALT_EN
            halt_pend_q <= halt_pend_d;
`endif
        end
    end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// ============================================================================
// tb_pc_fetch_ctrl
// ----------------------------------------------------------------------------
// Directed-vector bench for pc_fetch_ctrl. Each cycle the stimulus process
// sets the inputs and queues the outputs expected for that cycle. A monitor
// pops one entry per falling edge and compares it against the DUT outputs.
// ============================================================================
module tb_pc_fetch_ctrl;

    logic        CLK = 1'b0;
    logic        nRST = 1'b0;
    logic        ihit = 1'b0;
    logic        stall = 1'b0;
    logic [2:0]  pcsrc = 3'd0;
    logic        equal = 1'b0;
    logic [15:0] imm = 16'h0;
    logic [25:0] jaddr = 26'h0;
    logic [31:0] rs_data = 32'h0;
    logic [31:0] res_npc = 32'h0;
`ifdef PC_HALT_EN
    logic        halt = 1'b0;
`endif
    logic [31:0] imemaddr;
    logic        imemREN;
    logic [31:0] nPC;
    logic        flush;
    logic        drop_fetch;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] npc;
        logic        ren;
        logic        flush;
        logic        drop;
    } obs_t;

    obs_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   vec_id   = 0;

    pc_fetch_ctrl #(.RESET_PC(32'h0000_0000)) dut (
        .CLK        (CLK),
        .nRST       (nRST),
        .ihit       (ihit),
        .stall      (stall),
        .pcsrc      (pcsrc),
        .equal      (equal),
        .imm        (imm),
        .jaddr      (jaddr),
        .rs_data    (rs_data),
        .res_npc    (res_npc),
`ifdef PC_HALT_EN
        .halt       (halt),
`endif
        .imemaddr   (imemaddr),
        .imemREN    (imemREN),
        .nPC        (nPC),
        .flush      (flush),
        .drop_fetch (drop_fetch)
    );

    always #5 CLK = ~CLK;

    // Monitor: one expected record per cycle, checked mid-cycle.
    always @(negedge CLK) begin
        if (exp_q.size() > 0) begin
            obs_t e;
            obs_t a;
            e = exp_q.pop_front();
            a = '{addr: imemaddr, npc: nPC, ren: imemREN, flush: flush, drop: drop_fetch};
            n_checks++;
            if (a !== e) begin
                n_fail++;
                $display("FAIL vec%0d: got addr=%h npc=%h ren=%b flush=%b drop=%b, want addr=%h npc=%h ren=%b flush=%b drop=%b",
                         vec_id, a.addr, a.npc, a.ren, a.flush, a.drop,
                         e.addr, e.npc, e.ren, e.flush, e.drop);
            end
            vec_id++;
        end
    end

    task automatic next_cycle();
        @(posedge CLK);
        #1;
    endtask

    task automatic expect_out(input logic [31:0] a, input logic r,
                              input logic f, input logic d);
        exp_q.push_back('{addr: a, npc: a + 32'd4, ren: r, flush: f, drop: d});
    endtask

    task automatic ctl(input logic rstn, input logic ih, input logic st,
                       input logic [2:0] src, input logic eq);
        nRST  = rstn;
        ihit  = ih;
        stall = st;
        pcsrc = src;
        equal = eq;
    endtask

    initial begin
        // Reset and sequential fetch
        next_cycle(); ctl(0, 0, 0, 0, 0);          expect_out(32'h0, 0, 0, 0);
        next_cycle(); ctl(1, 1, 0, 0, 0);          expect_out(32'h0, 0, 0, 0);
        next_cycle(); ctl(1, 1, 0, 0, 0);          expect_out(32'h0, 1, 0, 0);
        next_cycle();                               expect_out(32'h4, 1, 0, 0);
        next_cycle();                               expect_out(32'h8, 1, 0, 0);
        next_cycle(); ctl(1, 0, 0, 0, 0);          expect_out(32'hC, 1, 0, 0);
        // J to 0x40 on hit
        next_cycle(); ctl(1, 1, 0, 3, 0); jaddr = 26'h10; res_npc = 32'h0;
                                                    expect_out(32'hC, 1, 1, 0);
        // Stall holds for two cycles, then steps
        next_cycle(); ctl(1, 1, 1, 0, 0);          expect_out(32'h40, 1, 0, 0);
        next_cycle();                               expect_out(32'h40, 1, 0, 0);
        next_cycle(); ctl(1, 1, 0, 0, 0);          expect_out(32'h40, 1, 0, 0);
        // BEQ taken: 0x104 + (-2 << 2) = 0xFC
        next_cycle(); ctl(1, 1, 0, 1, 1); res_npc = 32'h104; imm = 16'hFFFE;
                                                    expect_out(32'h44, 1, 1, 0);
        // BEQ not taken: sequential
        next_cycle(); ctl(1, 1, 0, 1, 0);          expect_out(32'hFC, 1, 0, 0);
        // BNE taken: 0x104 + 16 = 0x114
        next_cycle(); ctl(1, 1, 0, 2, 0); imm = 16'h0004;
                                                    expect_out(32'h100, 1, 1, 0);
        // JR on a miss: park 0x200, drain after three idle cycles
        next_cycle(); ctl(1, 0, 0, 5, 0); rs_data = 32'h203;
                                                    expect_out(32'h114, 1, 1, 0);
        next_cycle(); ctl(1, 0, 0, 0, 0);          expect_out(32'h114, 1, 0, 0);
        next_cycle();                               expect_out(32'h114, 1, 0, 0);
        next_cycle();                               expect_out(32'h114, 1, 0, 0);
        next_cycle(); ctl(1, 1, 0, 0, 0);          expect_out(32'h114, 1, 0, 1);
        next_cycle(); ctl(1, 0, 0, 0, 0);          expect_out(32'h200, 1, 0, 0);
        // Two redirects during one miss: the younger (JAL) wins
        next_cycle(); ctl(1, 0, 0, 3, 0); jaddr = 26'h20; res_npc = 32'h0;
                                                    expect_out(32'h200, 1, 1, 0);
        next_cycle(); ctl(1, 0, 0, 4, 0); jaddr = 26'h30; res_npc = 32'h1000_0000;
                                                    expect_out(32'h200, 1, 1, 0);
        next_cycle(); ctl(1, 1, 0, 0, 0);          expect_out(32'h200, 1, 0, 1);
        // J under stall: redirect wins
        next_cycle(); ctl(1, 1, 1, 3, 0); jaddr = 26'h10; res_npc = 32'hF000_0004;
                                                    expect_out(32'h1000_00C0, 1, 1, 0);
        next_cycle(); ctl(1, 0, 0, 0, 0);          expect_out(32'hF000_0040, 1, 0, 0);
        // JR to 0xFFFFFFFC, then sequential wrap to 0
        next_cycle(); ctl(1, 1, 0, 5, 0); rs_data = 32'hFFFF_FFFF;
                                                    expect_out(32'hF000_0040, 1, 1, 0);
        next_cycle(); ctl(1, 1, 0, 0, 0);          expect_out(32'hFFFF_FFFC, 1, 0, 0);
        // pcsrc=6 behaves as SEQ
        next_cycle(); ctl(1, 1, 0, 6, 1);          expect_out(32'h0, 1, 0, 0);
        // Taken BEQ on a miss, then reset mid-drain discards the parked PC
        next_cycle(); ctl(1, 0, 0, 1, 1); res_npc = 32'h104; imm = 16'hFFFE;
                                                    expect_out(32'h4, 1, 1, 0);
        next_cycle(); ctl(0, 0, 0, 0, 0);          expect_out(32'h4, 1, 0, 0);
        next_cycle(); ctl(1, 1, 0, 0, 0);          expect_out(32'h0, 0, 0, 0);
        next_cycle();                               expect_out(32'h0, 1, 0, 0);
        next_cycle(); ctl(1, 0, 0, 0, 0);          expect_out(32'h4, 1, 0, 0);
`ifdef PC_HALT_EN
        // Halt freezes the PC, ignores redirects, and is cleared only by reset
        next_cycle(); halt = 1'b1;                 expect_out(32'h4, 1, 0, 0);
        next_cycle(); halt = 1'b0; ctl(1, 1, 0, 3, 0); jaddr = 26'h10; res_npc = 32'h0;
                                                    expect_out(32'h4, 0, 0, 0);
        next_cycle(); ctl(1, 1, 0, 0, 0);          expect_out(32'h4, 0, 0, 0);
        next_cycle(); ctl(0, 0, 0, 0, 0);          expect_out(32'h4, 0, 0, 0);
        next_cycle(); ctl(1, 1, 0, 0, 0);          expect_out(32'h0, 0, 0, 0);
        next_cycle();                               expect_out(32'h0, 1, 0, 0);
`endif
        @(negedge CLK);
        #1;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expected records left unchecked, want 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
